// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM state type for the byte-serial adder.
package serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {FIRST = 1'b0, MID = 1'b1} sa_state_t;

endpackage

// File: rtl/serial_byte_adder_adder.sv
// Combinational W-bit adder cell: sum, carry-out and the full (W+1)-bit result.
module adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [W:0]   result
);

  assign result = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum    = result[W-1:0];
  assign cout   = result[W];

endmodule

// File: rtl/serial_byte_adder.sv
// Byte-serial multi-precision adder: one operand byte pair per beat, LSB first,
// with a single registered output stage and a carry held between beats.
module serial_byte_adder
  import serial_adder_pkg::*;
#(
  parameter int MAX_BYTES = 16,
  parameter int IDX_W     = $clog2(MAX_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err
);

  sa_state_t         state_reg;
  logic              carry_reg;
  logic [IDX_W-1:0]  idx_reg;

  logic              accept;
  logic              add_cin;
  logic [BYTE_W-1:0] add_sum;
  logic              add_cout;
  logic [BYTE_W:0]   unused_result;
  logic [IDX_W-1:0]  cur_idx;
  logic              at_limit;
  logic              forced_last;
  logic              beat_last;

  // Output register refills in the same cycle it is drained.
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign add_cin     = (state_reg == FIRST) ? in_cin : carry_reg;
  assign cur_idx     = (state_reg == FIRST) ? '0 : idx_reg;
  assign at_limit    = (cur_idx == IDX_W'(MAX_BYTES - 1));
  assign forced_last = at_limit && !in_last;
  assign beat_last   = in_last || at_limit;

  adder #(
    .W(BYTE_W)
  ) u_adder (
    .a      (in_a),
    .b      (in_b),
    .cin    (add_cin),
    .sum    (add_sum),
    .cout   (add_cout),
    .result (unused_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= FIRST;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_idx   <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_idx   <= cur_idx;
      out_last  <= beat_last;
      out_cout  <= beat_last && add_cout;
      out_err   <= forced_last;
      // A truncated packet ends exactly like a normal one: next beat restarts.
      if (beat_last) begin
        state_reg <= FIRST;
        carry_reg <= 1'b0;
        idx_reg   <= '0;
      end else begin
        state_reg <= MID;
        carry_reg <= add_cout;
        idx_reg   <= cur_idx + IDX_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_byte_adder.sv
// Randomized and directed bench for serial_byte_adder (MAX_BYTES=4) against a packet-arithmetic model.
module tb_serial_byte_adder;

  localparam int MB = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [7:0]    sum;
    logic          last;
    logic          cout;
    logic [IW-1:0] idx;
    logic          err;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_a = '0;
  logic [7:0]    in_b = '0;
  logic          in_cin = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_sum;
  logic          out_last;
  logic          out_cout;
  logic [IW-1:0] out_idx;
  logic          out_err;

  int n_vec = 0;
  int n_bad = 0;
  logic rnd_bp = 1'b0;

  serial_byte_adder #(.MAX_BYTES(MB), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
    .out_idx(out_idx), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet value as plain integers, expected beats in a queue.
  beat_t           exp_q[$];
  int              pkt_idx = 0;
  longint unsigned acc_a = 0;
  longint unsigned acc_b = 0;
  longint unsigned total = 0;
  logic            cin0 = 1'b0;
  logic            exp_ov = 1'b0;

  always @(negedge clk) begin
    logic  exp_ir;
    logic  acc;
    logic  lst;
    beat_t got;
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      pkt_idx = 0;
      exp_ov  = 1'b0;
    end else begin
      exp_ir = !exp_ov || out_ready;
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      if (exp_ov) begin
        if (exp_q.size() == 0) begin
          chk("q_empty", 32'd0, 32'd1);
        end else begin
          got = {out_sum, out_last, out_cout, out_idx, out_err};
          chk("beat", 32'(got), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (out_valid && !out_last) chk("cout_nonlast", 32'(out_cout), 32'd0);
      acc = in_valid && exp_ir;
      if (acc) begin
        if (pkt_idx == 0) begin
          acc_a = 0;
          acc_b = 0;
          cin0  = in_cin;
        end
        acc_a = acc_a | (64'(in_a) << (8 * pkt_idx));
        acc_b = acc_b | (64'(in_b) << (8 * pkt_idx));
        total = acc_a + acc_b + 64'(cin0);
        lst    = in_last || (pkt_idx == MB - 1);
        e.sum  = 8'(total >> (8 * pkt_idx));
        e.last = lst;
        e.cout = lst ? 1'(total >> (8 * (pkt_idx + 1))) : 1'b0;
        e.idx  = IW'(pkt_idx);
        e.err  = !in_last && (pkt_idx == MB - 1);
        exp_q.push_back(e);
        pkt_idx = lst ? 0 : pkt_idx + 1;
      end
      exp_ov = acc ? 1'b1 : ((exp_ov && out_ready) ? 1'b0 : exp_ov);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic l, output int cyc);
    logic acc;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; in_last = l;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 50) begin
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!acc) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] s, input logic l,
                         input logic co, input logic [IW-1:0] ix, input logic er);
    chk(tag, 32'({out_valid, out_sum, out_last, out_cout, out_idx, out_err}),
        32'({1'b1, s, l, co, ix, er}));
  endtask

  initial begin
    int cyc;
    int len;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 32'({out_valid, out_sum, out_last, out_cout, out_idx, out_err}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-byte packets.
    send(8'd1, 8'd4, 1'b0, 1'b1, cyc);  chk_out("sb_1_4", 8'h05, 1'b1, 1'b0, 2'd0, 1'b0);
    send(8'd7, 8'd2, 1'b1, 1'b1, cyc);  chk_out("sb_7_2c", 8'h0A, 1'b1, 1'b0, 2'd0, 1'b0);
    send(8'd7, 8'd8, 1'b0, 1'b1, cyc);  chk_out("sb_7_8", 8'h0F, 1'b1, 1'b0, 2'd0, 1'b0);

    // 0x00FF + 0x0001
    send(8'hFF, 8'h01, 1'b0, 1'b0, cyc); chk_out("cp_b0", 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    send(8'h00, 8'h00, 1'b0, 1'b1, cyc); chk_out("cp_b1", 8'h01, 1'b1, 1'b0, 2'd1, 1'b0);

    // 0xFFFF + 0x0001, then carry must not leak into the next packet
    send(8'hFF, 8'h01, 1'b0, 1'b0, cyc); chk_out("co_b0", 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    send(8'hFF, 8'h00, 1'b0, 1'b1, cyc); chk_out("co_b1", 8'h00, 1'b1, 1'b1, 2'd1, 1'b0);
    send(8'h01, 8'h01, 1'b0, 1'b1, cyc); chk_out("co_next", 8'h02, 1'b1, 1'b0, 2'd0, 1'b0);

    // Backpressure: three stalled cycles mid-packet
    send(8'h10, 8'h20, 1'b0, 1'b0, cyc); chk_out("bp_b0", 8'h30, 1'b0, 1'b0, 2'd0, 1'b0);
    out_ready = 1'b0;
    fork
      send(8'h30, 8'h40, 1'b0, 1'b1, cyc);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_hold", 32'(out_sum), 32'h30);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    chk("bp_wait", 32'(cyc), 32'd4);
    chk_out("bp_b1", 8'h70, 1'b1, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(8'(i), 8'(i), 1'b0, 1'b1, cyc);
      chk("tput", 32'(cyc), 32'd1);
    end

    // Overflow: 5 beats, no last until the 5th
    for (int j = 0; j < 5; j++) begin
      send(8'hFF, 8'h00, (j == 0), (j == 4), cyc);
      if (j == 3) chk_out("ovf_b3", 8'h00, 1'b1, 1'b1, 2'd3, 1'b1);
      if (j == 4) chk_out("ovf_b4", 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0);
    end

    // Reset mid-packet
    send(8'hFF, 8'h01, 1'b0, 1'b0, cyc);
    send(8'hFF, 8'h01, 1'b0, 1'b0, cyc);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_outs", 32'({out_valid, out_sum, out_last, out_cout, out_idx, out_err}), 32'd0);
    send(8'h01, 8'h01, 1'b0, 1'b1, cyc); chk_out("mrst_next", 8'h02, 1'b1, 1'b0, 2'd0, 1'b0);

    // Random packets with random backpressure and gaps
    rnd_bp = 1'b1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, MB + 1);
      for (int j = 0; j < len; j++) begin
        send(8'($urandom), 8'($urandom), 1'($urandom), (j == len - 1), cyc);
        if ($urandom_range(0, 4) == 0) begin
          out_ready = ($urandom_range(0, 1) != 0);
          @(posedge clk); #1;
        end
      end
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
